// File: rtl/regfile_param_clr_if.sv
// Bus between decode/writeback and the parametrised register file.
// reg_write and clear_req are plain enables sampled on every rising clk edge; there is
// no backpressure: busy only reports that a bulk clear is running and that writes are dropped.
interface regfile_param_clr_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  write_data;
  logic              reg_write;
  logic              clear_req;
  logic [WIDTH-1:0]  read_data1;
  logic [WIDTH-1:0]  read_data2;
  logic              busy;
  logic              fsm_state;

  modport master (
    output rs1, rs2, rd, write_data, reg_write, clear_req,
    input  read_data1, read_data2, busy, fsm_state
  );

  modport slave (
    input  rs1, rs2, rd, write_data, reg_write, clear_req,
    output read_data1, read_data2, busy, fsm_state
  );
endinterface

// File: rtl/regfile_param_clr.sv
// Parametrised integer register file: optional hardwired x0, write-to-read bypass,
// registered reads, and a one-entry-per-cycle bulk-clear engine.
module regfile_param_clr #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic               clk,
  input  logic               reset,
  regfile_param_clr_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  // x0 never needs clearing when it is hardwired, so the sweep starts at 1.
  localparam logic [ADDR_W:0] IDX_START = (ZERO_REG != 0) ? (ADDR_W+1)'(1) : '0;
  localparam logic [ADDR_W:0] IDX_LAST  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   idx;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic              busy_c;
  logic              clear_start;
  logic              write_q;
  logic [WIDTH-1:0]  rd1_c;
  logic [WIDTH-1:0]  rd2_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (idx == IDX_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c      = (state == ST_CLEAR);
    clear_start = (state == ST_IDLE) && bus.clear_req;
    // clear_req wins over a same-cycle write; the write is dropped, not deferred.
    write_q     = bus.reg_write && (state == ST_IDLE) && !bus.clear_req &&
                  !((ZERO_REG != 0) && (bus.rd == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            idx <= '0;
    else if (clear_start) idx <= IDX_START;
    else if (busy_c)      idx <= idx + (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (busy_c) begin
      regs[idx[ADDR_W-1:0]] <= '0;
    end else if (write_q) begin
      regs[bus.rd] <= bus.write_data;
    end
  end

  always_comb begin
    rd1_c = regs[bus.rs1];
    rd2_c = regs[bus.rs2];
    if ((BYPASS != 0) && write_q && (bus.rs1 == bus.rd)) rd1_c = bus.write_data;
    if ((BYPASS != 0) && write_q && (bus.rs2 == bus.rd)) rd2_c = bus.write_data;
    if ((ZERO_REG != 0) && (bus.rs1 == '0)) rd1_c = '0;
    if ((ZERO_REG != 0) && (bus.rs2 == '0)) rd2_c = '0;
  end

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [WIDTH-1:0] rd1_q;
      logic [WIDTH-1:0] rd2_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd1_q <= '0;
          rd2_q <= '0;
        end else begin
          rd1_q <= rd1_c;
          rd2_q <= rd2_c;
        end
      end
      assign bus.read_data1 = rd1_q;
      assign bus.read_data2 = rd2_q;
    end else begin : g_read_comb
      assign bus.read_data1 = rd1_c;
      assign bus.read_data2 = rd2_c;
    end
  endgenerate

  assign bus.busy      = busy_c;
  assign bus.fsm_state = state;

endmodule
